// File: rtl/soc_system_fifo_pkg.sv
// Shared types and constants for the HPS-to-stream FIFO: info register layout,
// MM address map and the stored entry format.
package soc_system_fifo_pkg;

  localparam int INFO_SOP       = 0;
  localparam int INFO_EOP       = 1;
  localparam int INFO_EMPTY_LSB = 2;
  localparam int INFO_CH_LSB    = 8;
  localparam int INFO_ERR_LSB   = 16;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_INFO = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  channel;
    logic [7:0]  error;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } entry_t;

  // Info register as seen on readback; unused bits read as zero.
  function automatic logic [31:0] info_word(input entry_t e);
    logic [31:0] w;
    w = '0;
    w[INFO_SOP]              = e.sop;
    w[INFO_EOP]              = e.eop;
    w[INFO_EMPTY_LSB +: 2]   = e.empty;
    w[INFO_CH_LSB +: 8]      = e.channel;
    w[INFO_ERR_LSB +: 8]     = e.error;
    return w;
  endfunction

endpackage

// File: rtl/soc_system_fifo_ram_sc.sv
// Single-clock simple dual-port RAM FIFO core; head is read from the registered
// read pointer so it is valid whenever the core is non-empty.
module soc_system_fifo_ram_sc
  import soc_system_fifo_pkg::*;
#(
  parameter int ENTRIES = 31,
  parameter int AW      = 5
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t wr_dat,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam logic [AW-1:0] LAST     = AW'(ENTRIES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(ENTRIES);
  localparam logic [AW:0]   ONE      = (AW+1)'(1);

  entry_t          mem [ENTRIES];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     used;

  assign empty = (used == '0);
  assign full  = (used == FULL_CNT);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Entry count is not a power of two, so pointers wrap explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   used <= used + ONE;
        2'b01:   used <= used - ONE;
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/soc_system_fifo_mm_to_st.sv
// HPS Avalon-MM write slave feeding an Avalon-ST source through a RAM FIFO plus
// a registered output stage; a push into an empty block bypasses the RAM.
module soc_system_fifo_mm_to_st
  import soc_system_fifo_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic              avalonmm_write_slave_address,
  input  logic              avalonmm_write_slave_write,
  input  logic [31:0]       avalonmm_write_slave_writedata,
  input  logic              avalonmm_write_slave_read,
  output logic [31:0]       avalonmm_write_slave_readdata,
  output logic              avalonmm_write_slave_waitrequest,
  output logic [31:0]       avalonst_source_data,
  output logic              avalonst_source_valid,
  input  logic              avalonst_source_ready,
  output logic [7:0]        avalonst_source_channel,
  output logic [7:0]        avalonst_source_error,
  output logic [1:0]        avalonst_source_empty,
  output logic              avalonst_source_startofpacket,
  output logic              avalonst_source_endofpacket,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  entry_t          info;
  entry_t          stage;
  entry_t          ram_head;
  entry_t          in_entry;
  logic [ADDR_W:0] count;
  logic            stage_vld;
  logic            ram_empty;
  logic            ram_full;
  logic            is_data;
  logic            blk_full;
  logic            push;
  logic            pop;
  logic            stage_load;
  logic            ram_push;
  logic            ram_pop;

  assign is_data    = (avalonmm_write_slave_address == ADDR_DATA);
  assign blk_full   = (count == FULL_CNT);
  assign push       = avalonmm_write_slave_write & is_data & ~blk_full;
  assign pop        = stage_vld & avalonst_source_ready;
  assign stage_load = ~stage_vld | pop;
  assign ram_pop    = stage_load & ~ram_empty;
  // Bypass only when the RAM holds nothing, which keeps ordering strictly FIFO.
  assign ram_push   = push & ~(stage_load & ram_empty) & ~ram_full;

  always_comb begin
    in_entry      = info;
    in_entry.data = avalonmm_write_slave_writedata;
  end

  soc_system_fifo_ram_sc #(
    .ENTRIES (DEPTH - 1),
    .AW      (ADDR_W)
  ) u_ram (
    .clk    (wrclock),
    .reset  (reset),
    .push   (ram_push),
    .wr_dat (in_entry),
    .pop    (ram_pop),
    .head   (ram_head),
    .empty  (ram_empty),
    .full   (ram_full)
  );

  always_ff @(posedge wrclock) begin
    if (reset) begin
      stage_vld                     <= 1'b0;
      stage                         <= '0;
      count                         <= '0;
      info                          <= '0;
      avalonmm_write_slave_readdata <= '0;
    end else begin
      if (stage_load) begin
        if (!ram_empty) begin
          stage     <= ram_head;
          stage_vld <= 1'b1;
        end else if (push) begin
          stage     <= in_entry;
          stage_vld <= 1'b1;
        end else begin
          stage_vld <= 1'b0;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase

      // SOP/EOP are one-shot markers for the next pushed word; the rest persist.
      if (avalonmm_write_slave_write && !is_data) begin
        info.sop     <= avalonmm_write_slave_writedata[INFO_SOP];
        info.eop     <= avalonmm_write_slave_writedata[INFO_EOP];
        info.empty   <= avalonmm_write_slave_writedata[INFO_EMPTY_LSB +: 2];
        info.channel <= avalonmm_write_slave_writedata[INFO_CH_LSB +: 8];
        info.error   <= avalonmm_write_slave_writedata[INFO_ERR_LSB +: 8];
      end else if (push) begin
        info.sop <= 1'b0;
        info.eop <= 1'b0;
      end

      if (avalonmm_write_slave_read) begin
        avalonmm_write_slave_readdata <= is_data ? {{(31-ADDR_W){1'b0}}, count}
                                                 : info_word(info);
      end
    end
  end

  assign avalonmm_write_slave_waitrequest = avalonmm_write_slave_write & is_data & blk_full;
  assign level                          = count;
  assign avalonst_source_valid          = stage_vld;
  assign avalonst_source_data           = stage.data;
  assign avalonst_source_channel        = stage.channel;
  assign avalonst_source_error          = stage.error;
  assign avalonst_source_empty          = stage.empty;
  assign avalonst_source_startofpacket  = stage.sop;
  assign avalonst_source_endofpacket    = stage.eop;

endmodule

// File: tb/tb_soc_system_fifo_mm_to_st.sv
// Scoreboard bench for soc_system_fifo_mm_to_st: accepted pushes queue the
// expected beat, the stream monitor pops and compares on every handshake.
module tb_soc_system_fifo_mm_to_st;

  logic        wrclock = 1'b0;
  logic        reset   = 1'b1;
  logic        addr    = 1'b0;
  logic        wr      = 1'b0;
  logic [31:0] wdata   = '0;
  logic        rd      = 1'b0;
  logic [31:0] rdata;
  logic        waitreq;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready = 1'b0;
  logic [7:0]  src_channel;
  logic [7:0]  src_error;
  logic [1:0]  src_empty;
  logic        src_sop;
  logic        src_eop;
  logic [5:0]  level;

  int vectors     = 0;
  int miscompares = 0;
  int stalls      = 0;
  int cyc         = 0;
  int sop_seen    = 0;
  int eop_seen    = 0;

  logic [51:0] sb[$];
  logic        m_sop, m_eop;
  logic [1:0]  m_empty;
  logic [7:0]  m_ch, m_err;

  always #5 wrclock = ~wrclock;
  always @(posedge wrclock) cyc <= cyc + 1;

  soc_system_fifo_mm_to_st #(.DEPTH(32), .ADDR_W(5)) dut (
    .wrclock                          (wrclock),
    .reset                            (reset),
    .avalonmm_write_slave_address     (addr),
    .avalonmm_write_slave_write       (wr),
    .avalonmm_write_slave_writedata   (wdata),
    .avalonmm_write_slave_read        (rd),
    .avalonmm_write_slave_readdata    (rdata),
    .avalonmm_write_slave_waitrequest (waitreq),
    .avalonst_source_data             (src_data),
    .avalonst_source_valid            (src_valid),
    .avalonst_source_ready            (src_ready),
    .avalonst_source_channel          (src_channel),
    .avalonst_source_error            (src_error),
    .avalonst_source_empty            (src_empty),
    .avalonst_source_startofpacket    (src_sop),
    .avalonst_source_endofpacket      (src_eop),
    .level                            (level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wrclock);
      #1;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    m_sop = 1'b0; m_eop = 1'b0; m_empty = 2'd0; m_ch = 8'd0; m_err = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b0;
    @(posedge wrclock);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Called and returns at posedge+1; holds the write until waitrequest drops.
  task automatic mm_write(input logic a, input logic [31:0] d);
    int n;
    n = 0;
    addr = a; wdata = d; wr = 1'b1;
    @(negedge wrclock);
    while (waitreq && n < 200) begin
      stalls++;
      n++;
      @(negedge wrclock);
    end
    if (waitreq) begin
      check("wr_timeout", {63'd0, waitreq}, 64'd0);
    end else if (a == 1'b0) begin
      sb.push_back({d, m_ch, m_err, m_empty, m_sop, m_eop});
      m_sop = 1'b0;
      m_eop = 1'b0;
    end else begin
      m_sop = d[0]; m_eop = d[1]; m_empty = d[3:2]; m_ch = d[15:8]; m_err = d[23:16];
    end
    @(posedge wrclock);
    #1;
    wr = 1'b0;
  endtask

  task automatic mm_read(input logic a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(posedge wrclock);
    #1;
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    src_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    check("drain_left", sb.size(), 0);
    tick(2);
    check("drain_valid", {63'd0, src_valid}, 64'd0);
  endtask

  always @(negedge wrclock) begin
    if (!reset && src_valid && src_ready) begin
      if (sb.size() == 0) begin
        check("beat_expected", sb.size(), 1);
      end else begin
        check("beat", {src_data, src_channel, src_error, src_empty, src_sop, src_eop},
              {12'd0, sb.pop_front()});
      end
      if (src_sop) sop_seen++;
      if (src_eop) eop_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int start;

    clear_model();
    tick(2);
    do_reset();
    check("rst_valid", {63'd0, src_valid}, 64'd0);
    check("rst_waitreq", {63'd0, waitreq}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_level", level, 64'd0);
    check("rst_data", src_data, 64'd0);

    // Single word with info, bypass latency of one cycle.
    src_ready = 1'b1;
    mm_write(1'b1, 32'h0003_0A03);
    mm_write(1'b0, 32'h1111_1111);
    check("t1_valid", {63'd0, src_valid}, 64'd1);
    check("t1_data", src_data, 64'h1111_1111);
    check("t1_channel", src_channel, 64'h0A);
    check("t1_error", src_error, 64'h03);
    check("t1_sopeop", {src_sop, src_eop}, 64'd3);
    check("t1_empty", src_empty, 64'd0);
    mm_read(1'b1, d);
    check("t1_info_rb", d, 64'h0003_0A00);
    wait_drain();

    // Fill to full, held 33rd write released by a one-cycle ready pulse.
    src_ready = 1'b0;
    for (int i = 0; i < 32; i++) mm_write(1'b0, 32'(i));
    check("t2_level_full", level, 64'd32);
    fork
      mm_write(1'b0, 32'd32);
      begin
        @(negedge wrclock);
        check("t2_waitreq", {63'd0, waitreq}, 64'd1);
        @(posedge wrclock);
        #2;
        src_ready = 1'b1;
        @(posedge wrclock);
        #2;
        src_ready = 1'b0;
      end
    join
    check("t2_level_refill", level, 64'd32);
    wait_drain();

    // Streaming at one word per cycle.
    src_ready = 1'b1;
    stalls = 0;
    start = cyc;
    for (int i = 0; i < 16; i++) begin
      mm_write(1'b0, 32'h100 + 32'(i));
      check("t3_level", level, 64'd1);
    end
    check("t3_cycles", cyc - start, 64'd16);
    check("t3_stalls", stalls, 64'd0);
    wait_drain();

    // 10-word packet under toggling backpressure.
    sop_seen = 0;
    eop_seen = 0;
    src_ready = 1'b1;
    fork
      begin
        mm_write(1'b1, 32'h0000_0001);
        for (int i = 0; i < 10; i++) begin
          if (i == 9) mm_write(1'b1, 32'h0000_0002);
          mm_write(1'b0, 32'h200 + 32'(i));
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(posedge wrclock);
          #2;
          src_ready = ~src_ready;
        end
      end
    join
    wait_drain();
    check("t4_sop_count", sop_seen, 64'd1);
    check("t4_eop_count", eop_seen, 64'd1);

    // Reset in the middle of draining.
    src_ready = 1'b0;
    mm_write(1'b1, 32'h0005_0701);
    for (int i = 0; i < 5; i++) mm_write(1'b0, 32'h300 + 32'(i));
    src_ready = 1'b1;
    tick(2);
    do_reset();
    check("t5_valid", {63'd0, src_valid}, 64'd0);
    check("t5_level", level, 64'd0);
    mm_write(1'b0, 32'hDEAD_BEEF);
    check("t5_channel", src_channel, 64'd0);
    check("t5_sop", {63'd0, src_sop}, 64'd0);
    wait_drain();

    // Level and info readback.
    src_ready = 1'b0;
    for (int i = 0; i < 7; i++) mm_write(1'b0, 32'h400 + 32'(i));
    mm_read(1'b0, d);
    check("t6_level_rb", d, 64'd7);
    mm_write(1'b1, 32'hFFAB_CD5F);
    mm_read(1'b1, d);
    check("t6_info_rb", d, 64'h00AB_CD0F);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
